// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and sizing for the 8x8 MAC array sequencer: state encoding,
// array instruction codes and the phase-counter width.
package mac_ctrl_pkg;

  localparam int ROW       = 8;
  localparam int COL       = 8;
  localparam int VEC_BW    = 8;
  localparam int GAP_CYC   = 16;
  localparam int DRAIN_MAX = 64;

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // One counter serves every phase, so it must hold the longest phase length.
  localparam int CNT_MAX = max2(max2(COL, GAP_CYC), max2(DRAIN_MAX, (1 << VEC_BW) - 1));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Host/array-facing bundle of the MAC array sequencer. The perf counters
// exist only when MAC_ARRAY_CTRL_PERF_EN is defined.
interface mac_array_ctrl_if;
  import mac_ctrl_pkg::*;

  logic              start;
  logic [VEC_BW-1:0] num_vec;
  logic [1:0]        inst_w;
  logic              l0_rd;
  logic [COL-1:0]    valid_in;
  logic [COL-1:0]    ofifo_wr;
  logic              busy;
  logic              done;
  logic              err;
  logic [VEC_BW-1:0] out_cnt;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0]       cyc_cnt;
  logic [15:0]       stall_cnt;
`endif

  modport master (
    input  start, num_vec, valid_in,
    output inst_w, l0_rd, ofifo_wr, busy, done, err, out_cnt
`ifdef MAC_ARRAY_CTRL_PERF_EN
    , output cyc_cnt, stall_cnt
`endif
  );

  modport slave (
    output start, num_vec, valid_in,
    input  inst_w, l0_rd, ofifo_wr, busy, done, err, out_cnt
`ifdef MAC_ARRAY_CTRL_PERF_EN
    , input cyc_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/mac_array_ctrl_cnt.sv
// Loadable down-counter with a zero flag; it times every sequencer phase and
// stops at zero instead of wrapping.
module mac_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the weight-stationary MAC array: load, gap, execute, drain.
// Optional perf counters (cyc_cnt, stall_cnt) under MAC_ARRAY_CTRL_PERF_EN.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mac_array_ctrl_if.master  ctrl_if
);

  state_e            state_q;
  state_e            state_d;
  logic [VEC_BW-1:0] num_vec_q;
  logic [VEC_BW-1:0] out_cnt_q;
  logic [VEC_BW-1:0] out_cnt_d;
  logic [1:0]        inst_q;
  logic [1:0]        inst_d;
  logic              l0_rd_q;
  logic              l0_rd_d;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              err_d;
  logic              start_acc_s;
  logic              err_set_s;
  logic              count_s;
  logic              cnt_load_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cnt_zero_s;

  assign start_acc_s = ctrl_if.start && (state_q == IDLE);

  // Phase transitions; the DRAIN exit looks at the post-increment count so the
  // last vector ends the drain in the cycle it arrives.
  always_comb begin
    state_d   = state_q;
    err_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (cnt_zero_s) begin
          state_d = GAP;
        end else begin
          state_d = LOAD;
        end
      end
      GAP: begin
        if (cnt_zero_s) begin
          if (num_vec_q == {VEC_BW{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = GAP;
        end
      end
      EXEC: begin
        if (cnt_zero_s) begin
          state_d = DRAIN;
        end else begin
          state_d = EXEC;
        end
      end
      DRAIN: begin
        if (out_cnt_d == num_vec_q) begin
          state_d = DONE;
        end else if (cnt_zero_s) begin
          state_d   = DONE;
          err_set_s = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Collected-vector count: the last column marks a finished vector.
  always_comb begin
    count_s = ((state_q == EXEC) || (state_q == DRAIN)) &&
              ctrl_if.valid_in[COL-1] && (out_cnt_q != num_vec_q);
    if (start_acc_s) begin
      out_cnt_d = {VEC_BW{1'b0}};
    end else if (count_s) begin
      out_cnt_d = out_cnt_q + VEC_BW'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // Phase timer reload on every state change, and output/err next values.
  always_comb begin
    cnt_load_s = (state_d != state_q);
    case (state_d)
      LOAD:    cnt_val_s = CNT_W'(COL - 1);
      GAP:     cnt_val_s = CNT_W'(GAP_CYC - 1);
      EXEC:    cnt_val_s = CNT_W'(num_vec_q) - CNT_W'(1);
      DRAIN:   cnt_val_s = CNT_W'(DRAIN_MAX - 1);
      default: cnt_val_s = {CNT_W{1'b0}};
    endcase
    case (state_d)
      LOAD:    inst_d = INST_LOAD;
      EXEC:    inst_d = INST_EXEC;
      default: inst_d = INST_IDLE;
    endcase
    l0_rd_d = (state_d == LOAD) || (state_d == EXEC);
    if (start_acc_s) begin
      err_d = 1'b0;
    end else if (err_set_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  mac_ctrl_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (1'b1),
    .zero_o     (cnt_zero_s)
  );

  // FSM state and registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      num_vec_q <= {VEC_BW{1'b0}};
      out_cnt_q <= {VEC_BW{1'b0}};
      inst_q    <= INST_IDLE;
      l0_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc_s) begin
        num_vec_q <= ctrl_if.num_vec;
      end else begin
        num_vec_q <= num_vec_q;
      end
      out_cnt_q <= out_cnt_d;
      inst_q    <= inst_d;
      l0_rd_q   <= l0_rd_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      err_q     <= err_d;
    end
  end

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q;
  logic [15:0] stall_cnt_q;

  // Perf counters advance with the state being entered so they are final while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_q   <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else if (start_acc_s) begin
      cyc_cnt_q   <= 32'd1;
      stall_cnt_q <= 16'd0;
    end else begin
      if ((state_d != IDLE) && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end else begin
        cyc_cnt_q <= cyc_cnt_q;
      end
      if ((state_d == DRAIN) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign ctrl_if.cyc_cnt   = cyc_cnt_q;
  assign ctrl_if.stall_cnt = stall_cnt_q;
`endif

  assign ctrl_if.inst_w   = inst_q;
  assign ctrl_if.l0_rd    = l0_rd_q;
  assign ctrl_if.busy     = busy_q;
  assign ctrl_if.done     = done_q;
  assign ctrl_if.err      = err_q;
  assign ctrl_if.out_cnt  = out_cnt_q;
  // Combinational so the strobe lines up with the array's output data.
  assign ctrl_if.ofifo_wr = busy_q ? ctrl_if.valid_in : {COL{1'b0}};

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: tiles are described by their phase
// lengths and vector arrival times, and every cycle is checked against that.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mac_array_ctrl_if bus ();

  mac_array_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, k, obs, exp);
    end
  endtask

  // mode 0: vectors at random drain cycles, 1: vectors withheld (watchdog),
  // 2: last column valid through exec and drain, 3: vectors on drain cycles 1..n.
  // poke: extra starts during load, exec and the done cycle.
  task automatic run_tile(input int n, input int mode, input bit poke);
    bit             hit [DRAIN_MAX+1];
    int             d;
    int             t;
    int             p;
    int             dc;
    int             exp_inst;
    int             exp_out;
    bit             in_exec;
    bit             in_drain;
    logic [COL-1:0] v;
    for (int i = 0; i <= DRAIN_MAX; i++) hit[i] = 1'b0;
    p = 0;
    if (n == 0) begin
      d = 0;
    end else if (mode == 1) begin
      d = DRAIN_MAX;
    end else if (mode == 2) begin
      d = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        p = (mode == 3) ? (i + 1) : (p + int'($urandom_range(3, 1)));
        hit[p] = 1'b1;
      end
      d = p;
    end
    t = COL + GAP_CYC + n + d + 1;
    exp_out = (mode == 1) ? 0 : n;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.num_vec  = VEC_BW'(n);
    v            = COL'($urandom);
    bus.valid_in = v;
    #1;
    chk("idle_wr", -1, 32'(bus.ofifo_wr), 32'd0);

    for (int k = 0; k <= t; k++) begin
      @(negedge clk);
      bus.start   = poke && ((k == 3) || (k == COL + GAP_CYC) || (k == t - 1));
      bus.num_vec = VEC_BW'($urandom);
      in_exec  = (k >= COL + GAP_CYC) && (k < COL + GAP_CYC + n);
      in_drain = (n > 0) && (k >= COL + GAP_CYC + n) && (k < COL + GAP_CYC + n + d);
      dc       = k - (COL + GAP_CYC + n) + 1;
      v        = COL'($urandom);
      if (in_exec) begin
        v[COL-1] = (mode == 2);
      end else if (in_drain) begin
        v[COL-1] = (mode == 2) || (((mode == 0) || (mode == 3)) && hit[dc]);
      end
      bus.valid_in = v;
      #1;
      exp_inst = (k < COL) ? 1 : (in_exec ? 2 : 0);
      chk("inst_w", k, 32'(bus.inst_w), 32'(exp_inst));
      chk("l0_rd", k, 32'(bus.l0_rd), 32'(exp_inst != 0));
      chk("busy", k, 32'(bus.busy), 32'(k < t));
      chk("done", k, 32'(bus.done), 32'(k == t - 1));
      chk("ofifo_wr", k, 32'(bus.ofifo_wr), (k < t) ? 32'(v) : 32'd0);
      if (k == 0) begin
        chk("err_clr", k, 32'(bus.err), 32'd0);
        chk("cnt_clr", k, 32'(bus.out_cnt), 32'd0);
      end
      if (k >= t - 1) begin
        chk("out_cnt", k, 32'(bus.out_cnt), 32'(exp_out));
        chk("err", k, 32'(bus.err), 32'((mode == 1) && (n > 0)));
`ifdef MAC_ARRAY_CTRL_PERF_EN
        chk("cyc_cnt", k, bus.cyc_cnt, 32'(t));
        chk("stall_cnt", k, 32'(bus.stall_cnt), 32'(d));
`endif
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.num_vec  = '0;
    bus.valid_in = '0;
    repeat (3) @(negedge clk);
    bus.valid_in = '1;
    #1;
    chk("rst_inst", 0, 32'(bus.inst_w), 32'd0);
    chk("rst_l0", 0, 32'(bus.l0_rd), 32'd0);
    chk("rst_busy", 0, 32'(bus.busy), 32'd0);
    chk("rst_done", 0, 32'(bus.done), 32'd0);
    chk("rst_err", 0, 32'(bus.err), 32'd0);
    chk("rst_cnt", 0, 32'(bus.out_cnt), 32'd0);
    chk("rst_wr", 0, 32'(bus.ofifo_wr), 32'd0);
    @(negedge clk);
    reset        = 1'b1;
    bus.valid_in = '0;

    run_tile(4, 3, 1'b0);
    run_tile(0, 0, 1'b0);
    run_tile(3, 1, 1'b0);
    run_tile(5, 0, 1'b1);
    run_tile(8, 2, 1'b0);
    run_tile(1, 0, 1'b0);

    // Abort in the second exec cycle, then confirm a clean restart.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_vec = VEC_BW'(4);
    for (int k = 0; k <= COL + GAP_CYC + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    chk("pre_rst_inst", 0, 32'(bus.inst_w), 32'(INST_EXEC));
    bus.valid_in = '1;
    reset        = 1'b0;
    #1;
    chk("ar_inst", 0, 32'(bus.inst_w), 32'd0);
    chk("ar_l0", 0, 32'(bus.l0_rd), 32'd0);
    chk("ar_busy", 0, 32'(bus.busy), 32'd0);
    chk("ar_done", 0, 32'(bus.done), 32'd0);
    chk("ar_cnt", 0, 32'(bus.out_cnt), 32'd0);
    chk("ar_wr", 0, 32'(bus.ofifo_wr), 32'd0);
    @(negedge clk);
    reset        = 1'b1;
    bus.valid_in = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_busy", k, 32'(bus.busy), 32'd0);
      chk("post_rst_done", k, 32'(bus.done), 32'd0);
    end
    run_tile(2, 0, 1'b0);

    run_tile(255, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_tile(int'($urandom_range(8, 1)), int'($urandom_range(1, 0)) * 3, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
